display_score: RTL and testbench
================================

Name: display_score

Overview:
- Drives a 4-digit multiplexed 7-segment display (common-anode, active-low) with a 10-bit binary score, range 0..1023, shown in decimal.
- Converts the score to 4 BCD digits and time-multiplexes them onto one shared segment bus.
- Only one digit enable is active at a time.
- Sits between the game-score logic and the board's segment/anode pins.

Parameters:
- SCAN_DIV, default 100000, meaning: clock cycles each digit stays enabled before the scan advances. Must be >=1. At 100 MHz the default gives 1 ms per digit. Benches use 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_score  input  10  unsigned binary score, 0..1023.
- o_segment  output  8  segment drive, active-low. Bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.
- o_segment_an  output  4  digit enables, active-low, one-hot-low. Bit0=units (rightmost), bit1=tens, bit2=hundreds, bit3=thousands.

Behaviour:
- Reset (rst=0, asynchronous):
  - Scan counter=0, digit index=0, score register=0.
  - o_segment=8'hFF and o_segment_an=4'b1111 (display dark) for as long as rst is low.
- Score capture: i_score is registered every clock into score_q. Values are always in 0..1023, so no clamping is needed.
- Conversion:
  - score_q is converted combinationally (double-dabble or divide/modulo) into thousands, hundreds, tens and units.
  - Each digit is 0..9. Thousands is only ever 0 or 1.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - On reaching SCAN_DIV-1 it wraps to 0 and the digit index increments modulo 4 (0,1,2,3,0...).
- Output register: outputs are registered. Each cycle out of reset:
  - o_segment_an = ~(4'b0001 << index).
  - o_segment = pattern of the selected digit.
- Latency:
  - A change on i_score appears on o_segment no later than 2 clocks later, for whichever digit is currently enabled.
  - Scan timing is not disturbed by score changes.
- First cycle after reset release: o_segment_an=4'b1110 (units), and the units pattern for score_q.
- Patterns (active-low, dp off so bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF.
- Leading-zero blanking:
  - Thousands is blank if 0.
  - Hundreds is blank if thousands and hundreds are both 0.
  - Tens is blank if score_q<10.
  - Units is always shown, so 0 displays as a single "0".
- The anode is always driven for the indexed digit, even when that digit is blank; only o_segment=FF.
- Reset mid-scan: immediately blanks the outputs and restarts the scan at the units digit after release.
- No handshake. i_score may change on any cycle.

Test Plan (SCAN_DIV=2):
- Hold rst=0 with i_score=0 -> o_segment=FF, o_segment_an=1111 throughout. Release rst -> next edges show an=1110, seg=C0; tens, hundreds and thousands slots each show seg=FF with an=1101, 1011, 0111 in turn; index advances every 2 clocks.
- i_score=2 -> units slot C0 changes to A4 within 2 clocks; the other three slots stay FF.
- i_score=12 -> units A4, tens F9, hundreds FF, thousands FF.
- i_score=1023 -> units B0, tens A4, hundreds C0, thousands F9. Confirms an interior zero is not blanked.
- i_score=100 -> units C0, tens C0, hundreds F9, thousands FF.
- Assert rst low mid-scan while the tens digit is active -> outputs go FF/1111 asynchronously (before the next clk edge). After release the scan restarts at units (an=1110).

Source files
------------

// File: rtl/display_score.sv
// display_score: 10-bit binary score shown in decimal on a 4-digit multiplexed
// common-anode 7-segment display, with leading-zero blanking.
module display_score #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_score,
  output logic [7:0] o_segment,
  output logic [3:0] o_segment_an
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [9:0] score_q;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [25:0] dd;
  logic [15:0] bcd;
  logic [3:0] dig;
  logic blank;
  logic [7:0] seg_next;
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction
  // double-dabble: add 3 to any BCD nibble >= 5 before each shift
  always_comb begin
    dd = {16'd0, score_q};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++)
        if (dd[10+4*j +: 4] >= 4'd5) dd[10+4*j +: 4] = dd[10+4*j +: 4] + 4'd3;
      dd = dd << 1;
    end
    bcd = dd[25:10];
  end
  always_comb begin
    dig = bcd[{idx, 2'b00} +: 4];
    blank = idx == 2'd3 ? bcd[15:12] == 4'd0 :
            idx == 2'd2 ? bcd[15:8] == 8'd0 :
            idx == 2'd1 ? score_q < 10'd10 : 1'b0;
    seg_next = blank ? 8'hFF : seg7(dig);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
      cnt <= '0;
      idx <= '0;
      o_segment <= 8'hFF;
      o_segment_an <= 4'b1111;
    end else begin
      score_q <= i_score;
      cnt <= cnt == CW'(SCAN_DIV - 1) ? '0 : cnt + 1'b1;
      idx <= cnt == CW'(SCAN_DIV - 1) ? idx + 2'd1 : idx;
      o_segment <= seg_next;
      o_segment_an <= ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_display_score.sv
// tb_display_score: random and directed scores checked against a decimal
// reference model of the scanned display.
module tb_display_score;
  localparam int D = 2;
  logic clk = 0, rst = 0;
  logic [9:0] score = 0;
  logic [7:0] seg;
  logic [3:0] an;
  int n_chk = 0, n_pass = 0;
  int sq = 0, n = 0, last_k = -1;
  logic [7:0] es;
  logic [3:0] ea;
  logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int p10 [4] = '{1, 10, 100, 1000};
  int dir [5] = '{0, 2, 12, 1023, 100};

  display_score #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst(rst), .i_score(score), .o_segment(seg), .o_segment_an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (score %0d, cycle %0d)", tag, got, exp, sq, n);
  endtask

  function automatic logic [7:0] exp_seg(input int s, input int k);
    if ((k == 3 && s < 1000) || (k == 2 && s < 100) || (k == 1 && s < 10)) return 8'hFF;
    return pat[(s / p10[k]) % 10];
  endfunction

  task automatic step(input bit rnd);
    @(posedge clk);
    if (!rst) begin
      es = 8'hFF; ea = 4'hF; sq = 0; n = 0; last_k = -1;
    end else begin
      last_k = (n / D) % 4;
      ea = ~(4'b0001 << last_k);
      es = exp_seg(sq, last_k);
      sq = int'(score);
      n++;
    end
    #1;
    check("seg", seg, es);
    check("an", {4'h0, an}, {4'h0, ea});
    if (rnd) score = 10'($urandom_range(1023));
  endtask

  initial begin
    repeat (3) step(0);
    @(negedge clk) rst = 1;
    step(0);
    check("first_an", {4'h0, an}, 8'h0E);
    check("first_seg", seg, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      score = 10'(dir[i]);
      repeat (4 * D * 2) step(0);
    end
    repeat (400) step(1);
    score = 10'd1023;
    for (int g = 0; g < 12 && last_k != 1; g++) step(0);
    check("tens_active", {4'h0, an}, 8'h0D);
    #2 rst = 0;
    #1;
    check("async_seg", seg, 8'hFF);
    check("async_an", {4'h0, an}, 8'h0F);
    repeat (2) step(0);
    @(negedge clk) rst = 1;
    step(0);
    check("restart_an", {4'h0, an}, 8'h0E);
    repeat (300) step(1);
    score = 10'd999;
    repeat (4 * D * 2) step(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
